uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_pkg.sv | 16 +
 rtl/bit_timer.sv | 28 ++
 rtl/uart_tx_drain.sv | 107 ++++++++++
 tb/tb_uart_tx_drain.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_e;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter; o_bit_done marks the last cycle of each bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_bit_done = !i_clear && (r_count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from an upstream FIFO and sends each as an 8N1 frame, LSB first.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_enb,
    output logic       tx,
    output logic       busy,
    output logic [2:0] o_state
);

    tx_state_e  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_idx;
    logic       r_tx;
    logic       r_rd_enb;
    logic       r_busy;
    logic       w_clear;
    logic       w_bit_done;

    // Timer is held at zero until the frame starts, so START gets a full bit period.
    assign w_clear = (r_state == ST_IDLE) || (r_state == ST_POP) || (r_state == ST_LOAD);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .o_bit_done(w_bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_rd_enb <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (en && !fifo_empty) begin
                        r_state  <= ST_POP;
                        r_rd_enb <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_POP: begin
                    r_rd_enb <= 1'b0;
                    r_state  <= ST_LOAD;
                end
                // FIFO data becomes valid one edge after the pop request is sampled.
                ST_LOAD: begin
                    r_shift <= fifo_data;
                    r_idx   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= ST_START;
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tx     <= 1'b1;
                    r_rd_enb <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_enb = r_rd_enb;
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign o_state     = r_state;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench: frame-level reference model of the drain, random and directed traffic.
module tb_uart_tx_drain;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int FLEN  = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_enb;
    logic       tx;
    logic       busy;
    logic [2:0] state_dbg;

    uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_enb(fifo_rd_enb),
        .tx         (tx),
        .busy       (busy),
        .o_state    (state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream FIFO model: data registered on the edge that samples the read enable.
    logic [7:0] fifo_mem[$];
    logic [7:0] exp_q[$];
    int underflow = 0;

    always @(posedge clk) begin
        if (fifo_rd_enb) begin
            if (fifo_mem.size() == 0) underflow++;
            else fifo_data <= fifo_mem.pop_front();
        end
    end

    always @(negedge clk) fifo_empty = (fifo_mem.size() == 0);

    task automatic push_byte(input logic [7:0] b);
        fifo_mem.push_back(b);
        exp_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Reference model: a frame popped at edge E0 puts its bits on tx from E0+2,
    // each for CPB cycles; the line is busy until E0+2+FRAME_BITS*CPB.
    int         edge_n = 0;
    int         m_e0 = 0;
    bit         m_active = 0;
    logic [7:0] m_byte = 8'h00;
    logic [9:0] m_frame;
    int         m_off, m_k;
    logic       exp_tx = 1'b1;
    logic       exp_rd = 1'b0;
    logic       exp_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            exp_tx   = 1'b1;
            exp_rd   = 1'b0;
            exp_busy = 1'b0;
        end else begin
            edge_n++;
            if (m_active && (edge_n - 1) >= m_e0 + 2 + FLEN) m_active = 0;
            if (!m_active && en && !fifo_empty && exp_q.size() != 0) begin
                m_active = 1;
                m_e0     = edge_n;
                m_byte   = exp_q.pop_front();
            end
            exp_tx   = 1'b1;
            exp_rd   = 1'b0;
            exp_busy = 1'b0;
            if (m_active) begin
                m_off    = edge_n - m_e0;
                exp_rd   = (m_off == 0);
                exp_busy = (m_off <= 1 + FLEN);
                if (m_off >= 2 && m_off < 2 + FLEN) begin
                    m_k     = (m_off - 2) / CPB;
                    m_frame = {1'b1, m_byte, 1'b0};
                    exp_tx  = m_frame[m_k];
                end
            end
        end
    end

    int pops = 0;
    int busy_run = 0;
    int busy_len = 0;
    int high_run = 0;
    int last_high_run = 0;

    always @(negedge clk) begin
        chk("tx", {31'd0, tx}, {31'd0, exp_tx});
        chk("rd_enb", {31'd0, fifo_rd_enb}, {31'd0, exp_rd});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (fifo_rd_enb) pops++;
        if (busy) busy_run++;
        else begin
            if (busy_run != 0) busy_len = busy_run;
            busy_run = 0;
        end
        if (tx) high_run++;
        else begin
            if (high_run != 0) last_high_run = high_run;
            high_run = 0;
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pop(input int max_cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            #1;
            if (fifo_rd_enb) seen = 1;
        end
        if (!seen) chk("pop_timeout", 32'd0, 32'd1);
    endtask

    int p0;
    int n_rand;

    initial begin
        // Reset held for three cycles.
        run_cycles(3);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rd", {31'd0, fifo_rd_enb}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        run_cycles(2);

        // Single frame 0xA5.
        p0 = pops;
        push_byte(8'hA5);
        en = 1'b1;
        run_cycles(55);
        chk("a5_pops", pops - p0, 32'd1);
        chk("a5_busy_len", busy_len, 2 + FLEN);

        // Back-to-back frames, then an empty FIFO.
        p0 = pops;
        push_byte(8'h3C);
        push_byte(8'hFF);
        run_cycles(110);
        chk("b2b_pops", pops - p0, 32'd2);
        chk("b2b_gap", last_high_run, CPB + 3);
        chk("b2b_empty", {31'd0, fifo_empty}, 32'd1);

        // Empty FIFO with drain enabled.
        p0 = pops;
        run_cycles(100);
        chk("empty_pops", pops - p0, 32'd0);
        chk("empty_tx", {31'd0, tx}, 32'd1);
        chk("empty_busy", {31'd0, busy}, 32'd0);

        // Drop en in the middle of a frame.
        p0 = pops;
        push_byte(8'h81);
        push_byte(8'h55);
        wait_pop(10);
        run_cycles(2 + 2 * CPB + 2);
        en = 1'b0;
        run_cycles(80);
        chk("endrop_pops", pops - p0, 32'd1);
        chk("endrop_nonempty", {31'd0, fifo_empty}, 32'd0);
        en = 1'b1;
        run_cycles(55);
        chk("endrop_resume", pops - p0, 32'd2);

        // Asynchronous reset during data bit 3 of 0x81.
        push_byte(8'h81);
        wait_pop(10);
        push_byte(8'h5A);
        run_cycles(19);
        chk("prerst_tx", {31'd0, tx}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_tx", {31'd0, tx}, 32'd1);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        p0 = pops;
        run_cycles(3);
        chk("inrst_pops", pops - p0, 32'd0);
        rst_n = 1'b1;
        run_cycles(1);
        chk("postrst_pop", {31'd0, fifo_rd_enb}, 32'd1);
        run_cycles(50);

        // Random bytes with random enable toggling.
        n_rand = $urandom_range(6, 10);
        for (int i = 0; i < n_rand; i++) push_byte(8'($urandom_range(0, 255)));
        for (int i = 0; i < 1500 && exp_q.size() != 0; i++) begin
            en = ($urandom_range(0, 9) < 7);
            run_cycles($urandom_range(1, 6));
        end
        en = 1'b1;
        run_cycles(60);
        chk("rand_drained", exp_q.size(), 32'd0);
        chk("underflow", underflow, 32'd0);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
